mini_alu_core: RTL and testbench
================================

# mini_alu_core

Parametrised two-stage (fetch / execute) accumulator-free CPU core for the VGA display subsystem. It fetches 28-bit instructions from an external asynchronous instruction ROM and executes them against an internal register file. Results are forwarded between back-to-back instructions. It adds a bounded call/return stack, HALT, fault detection and a pipeline enable. It drives the LED register and registered video-memory write strobes for the frame-buffer RAM.

## Interface
- DATA_W, 16: datapath and register width.
- IP_W, 16: instruction-pointer width.
- STACK_DEPTH, 4: return-address stack entries (≥1).
- LED_W, 8: LED register width (≤ DATA_W).
- VADDR_W, 10: video-memory address width (≤ DATA_W).
- COLOR_W, 3: video pixel width (≤ DATA_W).

- Clock  in  1  sole clock, all state on rising edge.
- Reset  in  1  synchronous, active-high.
- iEnable  in  1  0 freezes all state; no writes or strobes are issued.
- oIP  out  IP_W  fetch address to ROM; combinational: branch target if a branch is taken this cycle, else the IP register.
- iInstruction  in  28  ROM data for oIP: [27:24] op, [23:16] dst, [15:8] src1, [7:0] src0.
- oLed  out  LED_W  LED register.
- oVideoWE  out  1  one-cycle video write strobe (registered).
- oVideoAddr  out  VADDR_W  video write address (registered).
- oVideoData  out  COLOR_W  video write pixel (registered).
- oHalted  out  1  core stopped (HALT or fault).
- oFault  out  1  sticky stack overflow/underflow flag.

## Operation
- Register file: 256 × DATA_W.
  - Synchronous read at src0/src1 of iInstruction, captured on the same edge as the F→E instruction register.
  - Write at E-end with dst. Contents are not reset.
- Forwarding: if the previous E wrote reg r and the current E reads r, the operand is the previous result, not RAM data. STO ignores operands.
- Opcodes:
  - 0 NOP.
  - 1 ADD: dst=s1+s0.
  - 2 SUB: dst=s1−s0.
  - 3 STO: dst={src1,src0} zero-extended/truncated to DATA_W.
  - 4 BLE: branch to dst if s1≤s0 (unsigned).
  - 5 JMP: branch to dst.
  - 6 CALL: push return address, branch to dst.
  - 7 RET: pop into IP.
  - 8 LED: oLed←s1[LED_W-1:0].
  - 9 WVM: video write addr=s0[VADDR_W-1:0], data=s1[COLOR_W-1:0].
  - A AND.
  - B OR.
  - C SHL: dst=s1<<s0[3:0].
  - D SHR: dst=s1>>s0[3:0] (logical).
  - E BEQ: branch to dst if s1==s0.
  - F HALT.
- Arithmetic wraps modulo 2^DATA_W.
- Branch target is dst zero-extended to IP_W.
- The IP register wraps 2^IP_W−1→0.
- Return address is the IP of the instruction in F during CALL's E (CALL address+1).
- State machine:
  - RUN: normal execution.
  - HALT: entered by op F. IP frozen, E holds NOP, oHalted=1.
  - FAULT: entered by CALL with STACK_DEPTH entries (overflow) or RET with 0 entries (underflow). No push/pop and no branch occurs; oFault=1, oHalted=1.
  - Only Reset leaves HALT or FAULT.

## Timing
- Reset values:
  - IP register 0; oIP=0.
  - E register=NOP; stack pointer 0.
  - oLed=0, oVideoWE=0, oVideoAddr=0, oVideoData=0.
  - oHalted=0, oFault=0; state RUN.
- Pipeline: the instruction at oIP in cycle n executes in cycle n+1. Register writeback and LED update occur at the end of n+1. oVideoWE is high in cycle n+2 for exactly one cycle.
- Taken branch/CALL/RET: oIP shows the target in the same cycle (zero penalty, no flush). The next-executed instruction is the target.
- Stack push/pop commit at the E edge. CALL immediately followed by RET returns correctly.
- HALT/fault: the instruction fetched during that E cycle is discarded. oHalted rises on the following edge.
- iEnable=0: IP, E register, stack, register file, state and LED hold; oVideoWE=0. The forwarding context is retained, so resuming is exact.
- Reset overrides iEnable and any state.

## Test plan
- Forwarding:
  - Stimulus: STO r1←5; STO r2←3; ADD r3=r2+r1; SUB r4=r3−r2; LED r4.
  - Required response: oLed=0x05 two cycles after LED is fetched; r3=8 without stalls.
- Branching:
  - Stimulus: BLE loop incrementing r1 from 0 to 10, then JMP; then BEQ on equal and unequal operands.
  - Required response: exactly 11 iterations; oIP equals the target in the branch's E cycle; no extra instruction executed.
- Call stack:
  - Stimulus: nested CALLs to depth 4, then 4 RETs.
  - Required response: each RET resumes at CALL address+1.
  - Stimulus: a 5th CALL.
  - Required response: oFault=1, oHalted=1, oIP frozen.
- Underflow / HALT:
  - Stimulus: RET with an empty stack.
  - Required response: FAULT.
  - Stimulus: HALT at address 0x12.
  - Required response: oIP stays 0x13; no register/LED/video activity; Reset returns oIP=0 and all flags to 0.
- Video write:
  - Stimulus: r1=0x3FF, r2=5, WVM.
  - Required response: oVideoWE high one cycle with addr 0x3FF, data 3'b101.
  - Stimulus: iEnable low for 3 cycles mid-loop.
  - Required response: identical final register/LED state vs. an uninterrupted run.

Source files
------------

// File: rtl/mini_alu_core_if.sv
// Bus bundle for mini_alu_core: enable, instruction ROM fetch port,
// LED register, video-memory write port and run-status flags.
interface mini_alu_core_if #(
  parameter int IP_W    = 16,
  parameter int LED_W   = 8,
  parameter int VADDR_W = 10,
  parameter int COLOR_W = 3
);
  logic               iEnable;
  logic [IP_W-1:0]    oIP;
  logic [27:0]        iInstruction;
  logic [LED_W-1:0]   oLed;
  logic               oVideoWE;
  logic [VADDR_W-1:0] oVideoAddr;
  logic [COLOR_W-1:0] oVideoData;
  logic               oHalted;
  logic               oFault;

  // Core side.
  modport master (
    input  iEnable, iInstruction,
    output oIP, oLed, oVideoWE, oVideoAddr, oVideoData, oHalted, oFault
  );

  // Environment side (ROM, LEDs, frame buffer).
  modport slave (
    output iEnable, iInstruction,
    input  oIP, oLed, oVideoWE, oVideoAddr, oVideoData, oHalted, oFault
  );
endinterface

// File: rtl/mini_alu_core.sv
// Two-stage (fetch / execute) core: 28-bit instructions from an async ROM,
// 256-entry register file with one-deep result forwarding, zero-penalty
// branches resolved in E, bounded return stack, HALT and stack-fault stop.
module mini_alu_core #(
  parameter int DATA_W      = 16,
  parameter int IP_W        = 16,
  parameter int STACK_DEPTH = 4,
  parameter int LED_W       = 8,
  parameter int VADDR_W     = 10,
  parameter int COLOR_W     = 3
) (
  input logic             Clock,
  input logic             Reset,
  mini_alu_core_if.master bus
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_STO = 4'h3,
    OP_BLE  = 4'h4, OP_JMP = 4'h5, OP_CALL = 4'h6, OP_RET = 4'h7,
    OP_LED  = 4'h8, OP_WVM = 4'h9, OP_AND = 4'hA, OP_OR  = 4'hB,
    OP_SHL  = 4'hC, OP_SHR = 4'hD, OP_BEQ = 4'hE, OP_HALT = 4'hF
  } op_t;

  // Result of the register-writing operations; other opcodes yield zero.
  function automatic logic [DATA_W-1:0] aluResult(
    input op_t              op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [15:0]       imm
  );
    case (op)
      OP_ADD:  aluResult = a + b;
      OP_SUB:  aluResult = a - b;
      OP_STO:  aluResult = DATA_W'(imm);
      OP_AND:  aluResult = a & b;
      OP_OR:   aluResult = a | b;
      OP_SHL:  aluResult = a << b[3:0];
      OP_SHR:  aluResult = a >> b[3:0];
      default: aluResult = '0;
    endcase
  endfunction

  state_t              state;
  logic [IP_W-1:0]     ipReg;
  logic [SP_W-1:0]     sp;
  logic [IP_W-1:0]     stack [STACK_DEPTH];
  logic [DATA_W-1:0]   regFile [256];

  logic                vld_p1;
  logic [27:0]         instr_p1;
  logic [DATA_W-1:0]   rd0_p1;
  logic [DATA_W-1:0]   rd1_p1;

  logic                fwdVld_p2;
  logic [7:0]          fwdDst_p2;
  logic [DATA_W-1:0]   fwdData_p2;

  logic [LED_W-1:0]    ledReg;
  logic                vidWe;
  logic [VADDR_W-1:0]  vidAddr;
  logic [COLOR_W-1:0]  vidData;

  op_t                 op;
  logic [7:0]          dst;
  logic [7:0]          src1;
  logic [7:0]          src0;
  logic [DATA_W-1:0]   s1;
  logic [DATA_W-1:0]   s0;
  logic [DATA_W-1:0]   result;
  logic                wrEn;
  logic                brTaken;
  logic [IP_W-1:0]     brTarget;
  logic                doPush;
  logic                doPop;
  logic                doHalt;
  logic                doFault;
  logic                doLed;
  logic                doWvm;
  logic [IP_W-1:0]     fetchIp;
  logic                advance;
  logic [IDX_W-1:0]    pushIdx;
  logic [IDX_W-1:0]    topIdx;

  // ---- E stage: decode, operand forwarding, branch resolution ----
  assign op   = op_t'(instr_p1[27:24]);
  assign dst  = instr_p1[23:16];
  assign src1 = instr_p1[15:8];
  assign src0 = instr_p1[7:0];

  // The previous E result is not yet visible in the register-file read.
  assign s1 = (fwdVld_p2 && fwdDst_p2 == src1) ? fwdData_p2 : rd1_p1;
  assign s0 = (fwdVld_p2 && fwdDst_p2 == src0) ? fwdData_p2 : rd0_p1;

  assign pushIdx = IDX_W'(sp);
  assign topIdx  = IDX_W'(sp - SP_W'(1));

  // Decode the E instruction into write, branch, stack and stop requests.
  always_comb begin
    wrEn     = 1'b0;
    brTaken  = 1'b0;
    brTarget = IP_W'(dst);
    doPush   = 1'b0;
    doPop    = 1'b0;
    doHalt   = 1'b0;
    doFault  = 1'b0;
    doLed    = 1'b0;
    doWvm    = 1'b0;
    result   = aluResult(op, s1, s0, {src1, src0});
    if (vld_p1 && state == ST_RUN) begin
      case (op)
        OP_ADD, OP_SUB, OP_STO, OP_AND, OP_OR, OP_SHL, OP_SHR: wrEn = 1'b1;
        OP_BLE:  brTaken = (s1 <= s0);
        OP_BEQ:  brTaken = (s1 == s0);
        OP_JMP:  brTaken = 1'b1;
        OP_CALL: begin
          if (sp == SP_W'(STACK_DEPTH)) begin
            doFault = 1'b1;
          end else begin
            doPush  = 1'b1;
            brTaken = 1'b1;
          end
        end
        OP_RET: begin
          if (sp == '0) begin
            doFault = 1'b1;
          end else begin
            doPop    = 1'b1;
            brTaken  = 1'b1;
            brTarget = stack[topIdx];
          end
        end
        OP_LED:  doLed  = 1'b1;
        OP_WVM:  doWvm  = 1'b1;
        OP_HALT: doHalt = 1'b1;
        default: ;
      endcase
    end
  end

  // Branch target goes straight to the ROM, so there is no penalty slot.
  assign fetchIp = brTaken ? brTarget : ipReg;
  assign advance = !Reset && bus.iEnable && state == ST_RUN && !doHalt && !doFault;

  // Control state: IP, stack pointer, run state, valids, LED and video strobe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ST_RUN;
      ipReg     <= '0;
      sp        <= '0;
      vld_p1    <= 1'b0;
      fwdVld_p2 <= 1'b0;
      ledReg    <= '0;
      vidWe     <= 1'b0;
      vidAddr   <= '0;
      vidData   <= '0;
    end else begin
      vidWe <= 1'b0;
      if (bus.iEnable && state == ST_RUN) begin
        if (doHalt || doFault) begin
          // The instruction fetched alongside the stopping one is dropped.
          state     <= doHalt ? ST_HALT : ST_FAULT;
          vld_p1    <= 1'b0;
          fwdVld_p2 <= 1'b0;
        end else begin
          ipReg     <= fetchIp + IP_W'(1);
          vld_p1    <= 1'b1;
          fwdVld_p2 <= wrEn;
          if (doPush) sp <= sp + SP_W'(1);
          if (doPop)  sp <= sp - SP_W'(1);
          if (doLed)  ledReg <= s1[LED_W-1:0];
          if (doWvm) begin
            vidWe   <= 1'b1;
            vidAddr <= s0[VADDR_W-1:0];
            vidData <= s1[COLOR_W-1:0];
          end
        end
      end
    end
  end

  // ---- F -> E boundary: instruction and register-file operands ----
  // Datapath storage: pipeline data, forwarding data, register file, stack.
  always_ff @(posedge Clock) begin
    if (advance) begin
      instr_p1   <= bus.iInstruction;
      rd0_p1     <= regFile[bus.iInstruction[7:0]];
      rd1_p1     <= regFile[bus.iInstruction[15:8]];
      // ---- E -> writeback boundary: forwarding context ----
      fwdDst_p2  <= dst;
      fwdData_p2 <= result;
      if (wrEn)   regFile[dst]    <= result;
      if (doPush) stack[pushIdx]  <= ipReg;
    end
  end

  assign bus.oIP        = fetchIp;
  assign bus.oLed       = ledReg;
  assign bus.oVideoWE   = vidWe;
  assign bus.oVideoAddr = vidAddr;
  assign bus.oVideoData = vidData;
  assign bus.oHalted    = (state != ST_RUN);
  assign bus.oFault     = (state == ST_FAULT);

endmodule

// File: tb/tb_mini_alu_core.sv
// Directed bench for mini_alu_core: programs are loaded into a behavioural
// async ROM and outputs are checked cycle by cycle against hand values.
module tb_mini_alu_core;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  mini_alu_core_if bus ();

  logic [27:0] rom [256];
  int nChecks = 0;
  int nFails  = 0;
  int callSeq [19] = '{'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h10, 'h20, 'h30, 'h40,
                       'h41, 'h31, 'h32, 'h21, 'h22, 'h11, 'h12, 'h06, 'h07};
  logic [15:0] heldIp;

  mini_alu_core dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  assign bus.iInstruction = rom[bus.oIP[7:0]];

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] d,
                                      input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic doReset();
    Reset       = 1'b1;
    bus.iEnable = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic loadLoop();
    clearRom();
    rom[0]  = ins(4'h3, 8'd1, 8'd0, 8'd0);   // r1 = 0
    rom[1]  = ins(4'h3, 8'd5, 8'd0, 8'd1);   // r5 = 1
    rom[2]  = ins(4'h3, 8'd6, 8'd0, 8'd10);  // r6 = 10
    rom[3]  = ins(4'h3, 8'd7, 8'd0, 8'd0);   // r7 = 0 (iterations)
    rom[4]  = ins(4'h1, 8'd7, 8'd7, 8'd5);   // r7++
    rom[5]  = ins(4'h1, 8'd1, 8'd1, 8'd5);   // r1++
    rom[6]  = ins(4'h4, 8'd4, 8'd1, 8'd6);   // BLE 4 if r1 <= r6
    rom[7]  = ins(4'h8, 8'd0, 8'd7, 8'd0);   // LED r7
    rom[8]  = ins(4'h5, 8'd10, 8'd0, 8'd0);  // JMP 10
    rom[9]  = ins(4'h8, 8'd0, 8'd5, 8'd0);   // skipped
    rom[10] = ins(4'hE, 8'd12, 8'd5, 8'd6);  // BEQ 12, 1 != 10
    rom[11] = ins(4'hE, 8'd13, 8'd1, 8'd1);  // BEQ 13, equal
    rom[12] = ins(4'h8, 8'd0, 8'd5, 8'd0);   // skipped
    rom[13] = ins(4'h1, 8'd8, 8'd1, 8'd6);   // r8 = 11 + 10
    rom[14] = ins(4'h8, 8'd0, 8'd8, 8'd0);   // LED r8
    rom[15] = ins(4'hF, 8'd0, 8'd0, 8'd0);   // HALT
  endtask

  initial begin
    bus.iEnable = 1'b1;
    clearRom();

    // Reset state
    doReset();
    check("rst_ip",     bus.oIP, 0);
    check("rst_led",    bus.oLed, 0);
    check("rst_we",     bus.oVideoWE, 0);
    check("rst_vaddr",  bus.oVideoAddr, 0);
    check("rst_vdata",  bus.oVideoData, 0);
    check("rst_halted", bus.oHalted, 0);
    check("rst_fault",  bus.oFault, 0);

    // Forwarding
    Reset = 1'b1;
    clearRom();
    rom[0] = ins(4'h3, 8'd1, 8'd0, 8'd5);
    rom[1] = ins(4'h3, 8'd2, 8'd0, 8'd3);
    rom[2] = ins(4'h1, 8'd3, 8'd2, 8'd1);
    rom[3] = ins(4'h2, 8'd4, 8'd3, 8'd2);
    rom[4] = ins(4'h8, 8'd0, 8'd4, 8'd0);
    rom[5] = ins(4'h8, 8'd0, 8'd3, 8'd0);
    rom[6] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    doReset();
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t <= 7) check("fwd_ip", bus.oIP, t);
      if (t == 5) check("fwd_led_before", bus.oLed, 8'h00);
      if (t == 6) check("fwd_led_sub", bus.oLed, 8'h05);
      if (t == 7) check("fwd_led_add", bus.oLed, 8'h08);
      if (t == 7) check("fwd_not_halted", bus.oHalted, 0);
      if (t == 8) check("fwd_halted", bus.oHalted, 1);
      if (t == 10) check("fwd_ip_frozen", bus.oIP, 7);
    end

    // Branching
    Reset = 1'b1;
    loadLoop();
    doReset();
    for (int t = 1; t <= 47; t++) begin
      tick();
      case (t)
        6:  check("br_ip_ble_fetch", bus.oIP, 6);
        7:  check("br_ip_ble_taken", bus.oIP, 4);
        37: check("br_ip_ble_exit", bus.oIP, 7);
        39: begin
              check("br_ip_jmp", bus.oIP, 10);
              check("br_led_iters", bus.oLed, 8'h0B);
            end
        40: check("br_ip_beq_ne", bus.oIP, 11);
        41: check("br_ip_beq_eq", bus.oIP, 13);
        43: check("br_led_no_skip", bus.oLed, 8'h0B);
        44: begin
              check("br_led_final", bus.oLed, 8'h15);
              check("br_not_halted", bus.oHalted, 0);
            end
        45: check("br_halted", bus.oHalted, 1);
        47: check("br_ip_final", bus.oIP, 16);
        default: ;
      endcase
    end

    // Enable gap mid-loop
    Reset = 1'b1;
    loadLoop();
    doReset();
    for (int t = 1; t <= 20; t++) tick();
    heldIp = bus.oIP;
    bus.iEnable = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      check("en_ip_hold", bus.oIP, heldIp);
      check("en_halted", bus.oHalted, 0);
    end
    bus.iEnable = 1'b1;
    for (int t = 1; t <= 30; t++) tick();
    check("en_led_final", bus.oLed, 8'h15);
    check("en_halted_final", bus.oHalted, 1);
    check("en_ip_final", bus.oIP, 16);

    // Nested calls to depth 4
    Reset = 1'b1;
    clearRom();
    rom['h00] = ins(4'h3, 8'd10, 8'd0, 8'd0);
    rom['h01] = ins(4'h3, 8'd11, 8'd0, 8'd1);
    rom['h02] = ins(4'h3, 8'd12, 8'd0, 8'd2);
    rom['h03] = ins(4'h3, 8'd13, 8'd0, 8'd4);
    rom['h04] = ins(4'h3, 8'd14, 8'd0, 8'd8);
    rom['h05] = ins(4'h6, 8'h10, 8'd0, 8'd0);
    rom['h06] = ins(4'h8, 8'd0, 8'd10, 8'd0);
    rom['h07] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    rom['h10] = ins(4'h6, 8'h20, 8'd0, 8'd0);
    rom['h11] = ins(4'h1, 8'd10, 8'd10, 8'd11);
    rom['h12] = ins(4'h7, 8'd0, 8'd0, 8'd0);
    rom['h20] = ins(4'h6, 8'h30, 8'd0, 8'd0);
    rom['h21] = ins(4'h1, 8'd10, 8'd10, 8'd12);
    rom['h22] = ins(4'h7, 8'd0, 8'd0, 8'd0);
    rom['h30] = ins(4'h6, 8'h40, 8'd0, 8'd0);
    rom['h31] = ins(4'h1, 8'd10, 8'd10, 8'd13);
    rom['h32] = ins(4'h7, 8'd0, 8'd0, 8'd0);
    rom['h40] = ins(4'h1, 8'd10, 8'd10, 8'd14);
    rom['h41] = ins(4'h7, 8'd0, 8'd0, 8'd0);
    doReset();
    for (int t = 1; t <= 18; t++) begin
      tick();
      check("call_ip_seq", bus.oIP, callSeq[t]);
    end
    tick();
    check("call_led_sum", bus.oLed, 8'h0F);
    tick();
    check("call_halted", bus.oHalted, 1);
    check("call_no_fault", bus.oFault, 0);

    // Fifth CALL overflows the stack
    Reset = 1'b1;
    clearRom();
    rom['h00] = ins(4'h6, 8'h10, 8'd0, 8'd0);
    rom['h10] = ins(4'h6, 8'h20, 8'd0, 8'd0);
    rom['h20] = ins(4'h6, 8'h30, 8'd0, 8'd0);
    rom['h30] = ins(4'h6, 8'h40, 8'd0, 8'd0);
    rom['h40] = ins(4'h6, 8'h50, 8'd0, 8'd0);
    doReset();
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t == 4) check("ovf_ip_depth4", bus.oIP, 'h40);
      if (t == 5) check("ovf_ip_no_branch", bus.oIP, 'h41);
      if (t == 5) check("ovf_fault_pre", bus.oFault, 0);
      if (t == 6) check("ovf_fault", bus.oFault, 1);
      if (t == 6) check("ovf_halted", bus.oHalted, 1);
      if (t == 9) check("ovf_ip_frozen", bus.oIP, 'h41);
    end

    // CALL followed directly by RET, then RET on an empty stack
    Reset = 1'b1;
    clearRom();
    rom['h00] = ins(4'h3, 8'd1, 8'd0, 8'h33);
    rom['h01] = ins(4'h6, 8'h10, 8'd0, 8'd0);
    rom['h10] = ins(4'h7, 8'd0, 8'd0, 8'd0);
    rom['h02] = ins(4'h8, 8'd0, 8'd1, 8'd0);
    rom['h03] = ins(4'h7, 8'd0, 8'd0, 8'd0);
    doReset();
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 2) check("ret_ip_call", bus.oIP, 'h10);
      if (t == 3) check("ret_ip_return", bus.oIP, 'h02);
      if (t == 5) check("ret_led", bus.oLed, 8'h33);
      if (t == 5) check("unf_ip", bus.oIP, 'h04);
      if (t == 6) check("unf_fault", bus.oFault, 1);
      if (t == 8) check("unf_ip_frozen", bus.oIP, 'h04);
    end

    // HALT at 0x12, then reset
    Reset = 1'b1;
    clearRom();
    rom['h00] = ins(4'h5, 8'h12, 8'd0, 8'd0);
    rom['h12] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    rom['h13] = ins(4'h9, 8'd0, 8'd0, 8'd0);
    rom['h14] = ins(4'h8, 8'd0, 8'd0, 8'd0);
    doReset();
    for (int t = 1; t <= 7; t++) begin
      tick();
      if (t == 1) check("halt_ip_jmp", bus.oIP, 'h12);
      if (t == 2) check("halt_not_yet", bus.oHalted, 0);
      if (t >= 3) begin
        check("halt_ip", bus.oIP, 'h13);
        check("halt_flag", bus.oHalted, 1);
        check("halt_no_we", bus.oVideoWE, 0);
      end
    end
    check("halt_led", bus.oLed, 0);
    check("halt_fault", bus.oFault, 0);
    Reset = 1'b1;
    tick();
    check("halt_rst_ip", bus.oIP, 0);
    check("halt_rst_halted", bus.oHalted, 0);
    check("halt_rst_fault", bus.oFault, 0);
    Reset = 1'b0;

    // Video write
    Reset = 1'b1;
    clearRom();
    rom[0] = ins(4'h3, 8'd1, 8'h03, 8'hFF);
    rom[1] = ins(4'h3, 8'd2, 8'h00, 8'h05);
    rom[2] = ins(4'h9, 8'd0, 8'd2, 8'd1);
    rom[3] = ins(4'hF, 8'd0, 8'd0, 8'd0);
    doReset();
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 3) check("vid_we_early", bus.oVideoWE, 0);
      if (t == 4) begin
        check("vid_we", bus.oVideoWE, 1);
        check("vid_addr", bus.oVideoAddr, 10'h3FF);
        check("vid_data", bus.oVideoData, 3'b101);
      end
      if (t == 5) check("vid_we_one_cycle", bus.oVideoWE, 0);
      if (t == 6) check("vid_addr_held", bus.oVideoAddr, 10'h3FF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
